// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial unsigned magnitude comparator sequencer.
// Walks the captured operands MSB first through a single 1-bit compare
// cell and stops on the first differing bit (or after bit 0 when equal).

// Single-bit compare cell; all outputs low when not enabled.
module serial_mag_comp_bit (
  input  logic a,
  input  logic b,
  input  logic en,
  output logic lt,
  output logic eq,
  output logic gt
);
  assign lt = en & ~a &  b;
  assign gt = en &  a & ~b;
  assign eq = en & ~(a ^ b);
endmodule

module serial_mag_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);
  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [IDXW-1:0]  idx;
  logic             cmp_en;
  logic             c_lt, c_eq, c_gt;
  logic             last_bit;

  // A compare is issued only while running and enabled.
  assign cmp_en   = (state == S_RUN) && en;
  assign last_bit = (idx == '0);

  serial_mag_comp_bit u_cell (
    .a  (op_a[idx]),
    .b  (op_b[idx]),
    .en (cmp_en),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: leave RUN on the first differing bit or after bit 0.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (c_lt || c_gt || (c_eq && last_bit)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from registered state.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Operand capture, bit index walk and held result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      idx  <= '0;
      lt   <= 1'b0;
      eq   <= 1'b0;
      gt   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_a <= a;
          op_b <= b;
          idx  <= IDXW'(WIDTH-1);
          lt   <= 1'b0;
          eq   <= 1'b0;
          gt   <= 1'b0;
        end
        S_RUN: begin
          if (c_lt)                 lt  <= 1'b1;
          else if (c_gt)            gt  <= 1'b1;
          else if (c_eq && last_bit) eq <= 1'b1;
          else if (c_eq)            idx <= idx - IDXW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Scoreboard bench for serial_mag_comp_ctrl: the driver pushes the expected
// result and busy length per accepted start, the monitor pops on done.
module tb_serial_mag_comp_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, en;
  logic [W-1:0] a, b;
  logic         busy, done, lt, eq, gt;

  serial_mag_comp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .a(a), .b(b),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;   // {lt,eq,gt}
    int         cyc;   // expected busy cycles
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic rst_seen = 1'b0;

  // Reference: number of compare cycles until the first differing bit.
  function automatic int exp_k(logic [W-1:0] x, logic [W-1:0] y);
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = W-1; i >= 0; i--) if (d[i]) return W - i;
    return W;
  endfunction

  function automatic logic [2:0] exp_res(logic [W-1:0] x, logic [W-1:0] y);
    return {x < y, x == y, x > y};
  endfunction

  always @(posedge clk) rst_seen <= rst;

  // Monitor: compares outputs against queued expectations.
  int         busy_cnt = 0;
  logic       have_res = 1'b0;
  logic [2:0] last_res = '0;
  always @(negedge clk) begin
    if (rst_seen) begin
      busy_cnt = 0;
      have_res = 1'b0;
      n_chk++;
      if ({busy, done, lt, eq, gt} != 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b want 00000", {busy, done, lt, eq, gt});
      end
    end else begin
      if (busy) begin
        busy_cnt++;
        n_chk++;
        if ({lt, eq, gt} != 3'b0) begin
          n_fail++;
          $display("FAIL run_flags: got %b want 000", {lt, eq, gt});
        end
      end
      if (done) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got done=1 want no pending compare");
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({lt, eq, gt} != e.res) begin
            n_fail++;
            $display("FAIL result: got %b want %b", {lt, eq, gt}, e.res);
          end
          n_chk++;
          if (busy_cnt != e.cyc) begin
            n_fail++;
            $display("FAIL latency: got %0d busy cycles want %0d", busy_cnt, e.cyc);
          end
          last_res = e.res;
          have_res = 1'b1;
        end
        busy_cnt = 0;
      end else if (!busy && have_res) begin
        n_chk++;
        if ({lt, eq, gt} != last_res) begin
          n_fail++;
          $display("FAIL held_result: got %b want %b", {lt, eq, gt}, last_res);
        end
      end
    end
  end

  // Driver: one compare, optional en pause, start re-pulse, or reset abort.
  task automatic do_cmp(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int pause_at, input int pause_len,
                        input bit repulse, input int reset_at);
    exp_t e;
    int   k, compares, pd, guard;
    bit   rp_done;
    k = exp_k(xa, xb);
    e.res = exp_res(xa, xb);
    e.cyc = k + ((pause_at < k) ? pause_len : 0);
    @(posedge clk); #1;
    a = xa; b = xb; start = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    q.push_back(e);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    compares = 0; pd = 0; guard = 0; rp_done = 1'b0;
    while (!done) begin
      if (compares == reset_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(q.pop_back());
        en = 1'b1;
        return;
      end
      start = 1'b0;
      if (repulse && !rp_done && compares == 1) begin
        start = 1'b1; a = 8'hFF; b = 8'h00; rp_done = 1'b1;
      end
      if (compares == pause_at && pd < pause_len) begin
        en = 1'b0; pd++;
      end else begin
        en = 1'b1; compares++;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: got no done after %0d cycles want done", guard);
        break;
      end
    end
    start = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int k, pat, plen, rat;
    rst = 1'b1; start = 1'b1; en = 1'b1;
    a = W'($urandom); b = W'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    do_cmp(8'h80, 8'h7F, 99, 0, 1'b0, -1);
    do_cmp(8'h12, 8'h13, 99, 0, 1'b0, -1);
    do_cmp(8'hA5, 8'hA5, 99, 0, 1'b0, -1);
    do_cmp(8'h0F, 8'h0E, 3, 3, 1'b0, -1);
    do_cmp(8'h12, 8'h13, 99, 0, 1'b1, -1);
    do_cmp(8'h12, 8'h13, 99, 0, 1'b0, 3);
    do_cmp(8'h01, 8'h02, 99, 0, 1'b0, -1);
    do_cmp(8'h00, 8'h00, 0, 2, 1'b0, -1);
    do_cmp(8'hFF, 8'hFE, 99, 0, 1'b0, -1);

    for (int t = 0; t < 60; t++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W-1));
        default: rb = W'($urandom);
      endcase
      k    = exp_k(ra, rb);
      pat  = $urandom_range(0, W-1);
      plen = $urandom_range(0, 3);
      rat  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, k-1) : -1;
      do_cmp(ra, rb, pat, plen, (k > 2) && ($urandom_range(0, 3) == 0), rat);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_mag_comp_ctrl.md
Name: serial_mag_comp_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned words bit-serially, MSB first.
- Uses one internal single-bit compare cell (a, b, enable -> lt, eq, gt), issuing one bit per clock.
- Stops early on the first differing bit and reports a registered lt/eq/gt result with a start/done handshake.
- Used where a full-width parallel magnitude comparator is too costly.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.
- IDXW, $clog2(WIDTH): width of the internal bit-index counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE.
- en  input  1  run enable; 0 freezes the RUN state (mirrors the cell's enable).
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  1 while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- lt  output  1  A < B; registered and held.
- eq  output  1  A == B; registered and held.
- gt  output  1  A > B; registered and held.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, lt=0, eq=0, gt=0; shift registers and index cleared. Reset mid-RUN aborts with no done pulse; the next edge without rst resumes from IDLE.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE:
  - start=1 -> capture a and b into internal registers, idx=WIDTH-1, clear lt/eq/gt to 0, go to RUN.
  - start=0 -> stay; lt/eq/gt keep their last result.
- RUN with en=0: hold everything (state, idx, operands); no compare is issued.
- RUN with en=1: compare bit idx of the captured A and B through the 1-bit cell, then:
  - bits differ -> set lt or gt per the cell output, go to DONE.
  - bits equal and idx==0 -> set eq=1, go to DONE.
  - bits equal and idx>0 -> idx=idx-1, stay in RUN.
- DONE: lasts exactly one cycle, then IDLE unconditionally. A start asserted during DONE is ignored; it is accepted only from the following IDLE cycle.
- start during RUN or DONE: ignored. Operand changes on a or b after acceptance have no effect.
- Latency: start is sampled at edge 0.
  - k = (WIDTH-1 - index of the highest differing bit) + 1, or k = WIDTH when the operands are equal.
  - done is high in the cycle following edge k + (number of en=0 cycles spent in RUN).
  - Minimum is 1 compare cycle; maximum is WIDTH compare cycles.
- Exactly one of lt/eq/gt is 1 from the DONE cycle until the next accepted start. All three are 0 during RUN and after reset.
- Arithmetic is unsigned. The index counter never underflows, because the transition out of RUN happens at idx==0.

Test Plan:
- Reset: hold rst=1 for 2 clocks, with start=1 and random a/b -> busy=done=lt=eq=gt=0 throughout; state IDLE.
- WIDTH=8, a=0x80, b=0x7F, start pulse -> busy for 1 cycle; done high for one cycle right after edge 1; gt=1, lt=eq=0, held afterwards.
- a=0x12, b=0x13 -> 8 compare cycles; done after edge 8; lt=1. Then a=0xA5, b=0xA5 -> done after edge 8; eq=1, lt cleared.
- a=0x0F, b=0x0E with en=0 for 3 cycles mid-RUN -> done after edge 11; gt=1; idx frozen during the pause.
- start re-pulsed during RUN, with a/b changed to 0xFF/0x00 -> ignored; the result matches the originally captured operands.
- rst=1 for one edge during RUN -> no done pulse; all outputs 0. A new start with a=0x01, b=0x02 then completes normally with lt=1 after 7 compare cycles.
